opb_register_simulink2ppc_coherent: RTL
=======================================

Name: opb_register_simulink2ppc_coherent

Overview:
- Read-back counterpart to the PPC-to-Simulink software registers: fabric logic writes a 64-bit value, and the PowerPC reads it over OPB as two 32-bit words.
- Reading the low word snapshots the high word, so a 64-bit read is coherent even if the user updates the value between the two reads.
- Also provides an update counter and overflow status word.
- Sits on the OPB bus alongside the other register slaves, in the single OPB_Clk domain.

Parameters:
- C_BASEADDR, 32'h01008200, first byte address of the 256-byte slave window.
- C_HIGHADDR, 32'h010082FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex6", target family string; no functional effect.

Ports:
- OPB_Clk  in  1  sole clock; all logic is rising-edge.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- OPB_ABus  in  [0:31]  OPB address; bit 31 is the LSB.
- OPB_BE  in  [0:3]  byte enables; BE[3] qualifies the control write.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master access strobe.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; must be zero except in the ack cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_in  in  [63:0]  value presented by the fabric.
- user_valid  in  1  when 1, user_data_in is loaded into the live register at this edge.

Behaviour:
- Reset (async assert, sync release): Sl_DBus = 0, Sl_xferAck = 0, live = 0, hi_shadow = 0, count = 0, ovf = 0, FSM = IDLE.
- Address hit: OPB_select = 1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset = OPB_ABus[28:29].
  - Offset 0: R, live[31:0].
  - Offset 1: R, hi_shadow.
  - Offset 2: R, status = {ovf, 15'b0, count[15:0]}.
  - Offset 3: W, control; reads return 0.
- FSM IDLE -> ACK on a hit. All side effects occur on this edge:
  - Read data is registered from pre-edge values.
  - Low-word read also loads hi_shadow <= live[63:32] (pre-edge value) and clears count.
- FSM ACK: Sl_xferAck = 1 and Sl_DBus = registered data for exactly 1 cycle. Next state is DESEL.
- FSM DESEL: Sl_xferAck = 0 and Sl_DBus = 0. Stay until OPB_select = 0, then go to IDLE. No second ack is issued while select is held.
- Latency: select/hit at edge N produces xferAck high in cycle N+1.
- Control write (offset 3, RNW = 0, BE[3] = 1): DBus[31] = 1 clears ovf.
- Writes to offsets 0-2 are acknowledged and ignored. Reads of offset 3 are acknowledged and return 0.
- user_valid = 1: live <= user_data_in.
  - count increments, saturating at 16'hFFFF.
  - If count is already 16'hFFFF, ovf <= 1 (sticky).
- Simultaneous user_valid and low-word read on the same edge:
  - The read returns the old live[31:0].
  - hi_shadow captures the old live[63:32].
  - count <= 1, because the clear wins and the new update is counted.
- Simultaneous user_valid and ovf-clear on the same edge: set wins, so ovf = 1 if count was saturated.
- An out-of-window access produces no ack, and Sl_DBus stays 0.
- A reset assertion mid-transaction drops xferAck and Sl_DBus to 0 immediately, and the FSM returns to IDLE.

Test Plan:
- Reset with no stimulus -> all outputs 0; a read of offset 2 returns 32'h00000000, with xferAck exactly 1 cycle after select.
- user_valid with 64'h1122334455667788; read offset 0, then pulse user_valid with 64'hAAAAAAAABBBBBBBB; read offset 1 -> reads return 32'h55667788 then 32'h11223344 (coherent).
- 3 user_valid pulses, then read offset 2 -> 32'h00000003; read offset 0 then offset 2 -> count reads 0.
- 65536 user_valid pulses -> status reads 32'h8000FFFF; write 32'h1 to offset 3 with BE = 4'hF -> status reads 32'h0000FFFF.
- user_valid coincident with a low-word read edge -> read returns the old low word, and a subsequent status read shows count = 1.
- Hold OPB_select for 5 cycles -> a single 1-cycle xferAck; an out-of-window access (0x01008300) -> no ack, Sl_DBus = 0.

Source files
------------

// File: rtl/opb_register_simulink2ppc_coherent_if.sv
// OPB slave-side signal bundle for the coherent 64-bit read-back register.
// Pure wiring; no latency of its own.
// No backpressure: the master holds OPB_select until it sees Sl_xferAck.
interface opb_register_simulink2ppc_coherent_if;
  // master -> slave request
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  // slave -> master response
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_coherent.sv
// Fabric-written 64-bit register read by the PPC as two coherent OPB words, plus update counter/overflow.
// Latency: a hit sampled at edge N gives a one-cycle Sl_xferAck in cycle N+1.
// No backpressure: user_valid is always accepted; OPB access is acked once per select assertion.
module opb_register_simulink2ppc_coherent #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010082FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  opb_register_simulink2ppc_coherent_if.slave opb,
  input  logic [63:0] user_data_in,
  input  logic        user_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DESEL = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state;
  state_t      state_nxt;

  // Live value written by the fabric, and the high word frozen at the last low-word read.
  logic [63:0] live;
  logic [31:0] hi_shadow;
  logic [15:0] count;
  logic        ovf;

  // Registered response; both are zero outside the ack cycle.
  logic        ack_q;
  logic [31:0] rd_dat_q;

  // Request decode.
  logic [31:0] addr;
  logic [1:0]  offset;
  logic        hit;
  logic        take;
  logic        rd_lo;
  logic        ctrl_clr;
  logic        cnt_sat;
  logic [31:0] rd_mux;

  assign addr    = opb.OPB_ABus;
  assign offset  = opb.OPB_ABus[28:29];
  assign hit     = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign cnt_sat = (count == CNT_MAX);

  // A low-word read is what freezes the high word and restarts the update count.
  assign rd_lo    = take && opb.OPB_RNW && (offset == 2'd0);
  // Overflow clear needs the last byte lane enabled and the LSB of the write data set.
  assign ctrl_clr = take && !opb.OPB_RNW && (offset == 2'd3)
                    && opb.OPB_BE[3] && opb.OPB_DBus[31];

  // Bits with no function here are gathered so that their lack of use is explicit.
  logic unused_inputs;
  assign unused_inputs = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:30],
                           (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32), |C_FAMILY};

  // Bus FSM: accept one access in IDLE, ack for one cycle, then wait out the select.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          state_nxt = ST_ACK;
          take      = 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_DESEL;
      end
      ST_DESEL: begin
        if (!opb.OPB_select) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read mux built from pre-edge register values; writes and control reads return zero.
  always_comb begin
    rd_mux = 32'h0;
    if (opb.OPB_RNW) begin
      case (offset)
        2'd0:    rd_mux = live[31:0];
        2'd1:    rd_mux = hi_shadow;
        2'd2:    rd_mux = {ovf, 15'b0, count};
        default: rd_mux = 32'h0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Response registers: data and ack are present only in the cycle after acceptance.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q    <= 1'b0;
      rd_dat_q <= 32'h0;
    end else begin
      ack_q    <= take;
      rd_dat_q <= take ? rd_mux : 32'h0;
    end
  end

  // Live value follows the fabric whenever it presents valid data.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      live <= 64'h0;
    end else if (user_valid) begin
      live <= user_data_in;
    end
  end

  // High word is captured from the pre-edge live value when the low word is read.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      hi_shadow <= 32'h0;
    end else if (rd_lo) begin
      hi_shadow <= live[63:32];
    end
  end

  // Update counter: a low-word read restarts it, and a coincident update is still counted.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      count <= 16'h0;
    end else if (rd_lo) begin
      count <= user_valid ? 16'h1 : 16'h0;
    end else if (user_valid && !cnt_sat) begin
      count <= count + 16'h1;
    end
  end

  // Sticky overflow: an update arriving at a saturated count sets it, and set beats clear.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ovf <= 1'b0;
    end else if (user_valid && cnt_sat) begin
      ovf <= 1'b1;
    end else if (ctrl_clr) begin
      ovf <= 1'b0;
    end
  end

  assign opb.Sl_DBus    = rd_dat_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule
